// File: rtl/pci_mem_target_if.sv
// PCI target-side signal bundle: sampled bus inputs plus separate out/oe pairs.
// Tri-state resolution happens in the wrapper that instantiates the target.
interface pci_mem_target_if;
    logic        pci_frame_ni;
    logic        pci_irdy_ni;
    logic [3:0]  pci_cbe_ni;
    logic [31:0] pci_ad_i;
    logic [31:0] pci_ad_o;
    logic        pci_ad_oe_o;
    logic        pci_par_o;
    logic        pci_par_oe_o;
    logic        pci_devsel_no;
    logic        pci_trdy_no;
    logic        pci_stop_no;
    logic        pci_ctl_oe_o;

    modport slave (
        input  pci_frame_ni, pci_irdy_ni, pci_cbe_ni, pci_ad_i,
        output pci_ad_o, pci_ad_oe_o, pci_par_o, pci_par_oe_o,
        output pci_devsel_no, pci_trdy_no, pci_stop_no, pci_ctl_oe_o
    );

    modport master (
        output pci_frame_ni, pci_irdy_ni, pci_cbe_ni, pci_ad_i,
        input  pci_ad_o, pci_ad_oe_o, pci_par_o, pci_par_oe_o,
        input  pci_devsel_no, pci_trdy_no, pci_stop_no, pci_ctl_oe_o
    );
endinterface

// File: rtl/pci_mem_target.sv
// PCI 32-bit memory target backed by an internal RAM: fast-decode, zero-wait-state
// bursts, disconnect-with-data at the top of the window.
module pci_mem_target #(
    parameter logic [31:0] ADDR_BASE  = 32'h0400_0000,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input logic             pci_clk_i,
    input logic             pci_rst_i,
    pci_mem_target_if.slave bus
);
    localparam int unsigned Words = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {StIdle, StWr, StRta, StRd, StDisc, StBkof} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] ptr_inc, addr_ptr;
    logic [31:0]           ad_q, ad_d;
    logic                  ad_oe_q, ad_oe_d;
    logic                  par_q, par_d;
    logic                  par_oe_q, par_oe_d;
    logic                  devsel_n_q, devsel_n_d;
    logic                  trdy_n_q, trdy_n_d;
    logic                  stop_n_q, stop_n_d;
    logic                  ctl_oe_q, ctl_oe_d;
    logic                  frame_prev_q, irdy_prev_q;
    logic                  addr_phase, cmd_rd, cmd_wr, win_hit, xfer, mem_we, go_bkof;
    logic [31:0]           mem [Words];

    assign addr_ptr   = bus.pci_ad_i[ADDR_WIDTH+1:2];
    assign ptr_inc    = ptr_q + ADDR_WIDTH'(1);
    assign cmd_rd     = bus.pci_cbe_ni inside {4'b0110, 4'b1100, 4'b1110};
    assign cmd_wr     = bus.pci_cbe_ni inside {4'b0111, 4'b1111};
    assign win_hit    = (bus.pci_ad_i[31:ADDR_WIDTH+2] == ADDR_BASE[31:ADDR_WIDTH+2]) &&
                        (bus.pci_ad_i[1:0] == 2'b00);
    // Start of a transaction only after a fully idle bus cycle.
    assign addr_phase = !bus.pci_frame_ni && frame_prev_q && irdy_prev_q;
    assign xfer       = !bus.pci_irdy_ni && !trdy_n_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ad_d       = ad_q;
        ad_oe_d    = ad_oe_q;
        devsel_n_d = devsel_n_q;
        trdy_n_d   = trdy_n_q;
        stop_n_d   = stop_n_q;
        ctl_oe_d   = ctl_oe_q;
        mem_we     = 1'b0;
        go_bkof    = 1'b0;
        par_oe_d   = ad_oe_q;
        par_d      = ad_oe_q ? ^{ad_q, bus.pci_cbe_ni} : par_q;

        unique case (state_q)
            StIdle: begin
                if (addr_phase && win_hit && (cmd_wr || cmd_rd)) begin
                    ptr_d      = addr_ptr;
                    devsel_n_d = 1'b0;
                    ctl_oe_d   = 1'b1;
                    if (cmd_wr) begin
                        state_d  = StWr;
                        trdy_n_d = 1'b0;
                        stop_n_d = ~&addr_ptr;
                    end else begin
                        state_d  = StRta;
                        trdy_n_d = 1'b1;
                        stop_n_d = 1'b1;
                    end
                end
            end
            StRta: begin
                state_d  = StRd;
                ad_d     = mem[ptr_q];
                ad_oe_d  = 1'b1;
                trdy_n_d = 1'b0;
                stop_n_d = ~&ptr_q;
            end
            StWr, StRd: begin
                if (xfer) begin
                    mem_we = (state_q == StWr) && !pci_rst_i;
                    if (bus.pci_frame_ni) begin
                        go_bkof = 1'b1;
                    end else if (&ptr_q) begin
                        // STOP# already low; keep it and DEVSEL# until FRAME# rises.
                        state_d  = StDisc;
                        trdy_n_d = 1'b1;
                        ad_oe_d  = 1'b0;
                    end else begin
                        ptr_d    = ptr_inc;
                        stop_n_d = ~&ptr_inc;
                        if (state_q == StRd) begin
                            ad_d = mem[ptr_inc];
                        end
                    end
                end
            end
            StDisc: begin
                if (bus.pci_frame_ni) begin
                    go_bkof = 1'b1;
                end
            end
            StBkof: begin
                state_d  = StIdle;
                ctl_oe_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        // Back-off: drive the control lines high for one clock before releasing them.
        if (go_bkof) begin
            state_d    = StBkof;
            devsel_n_d = 1'b1;
            trdy_n_d   = 1'b1;
            stop_n_d   = 1'b1;
            ad_oe_d    = 1'b0;
            ctl_oe_d   = 1'b1;
        end
    end

    always_ff @(posedge pci_clk_i) begin
        if (pci_rst_i) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            ad_q         <= '0;
            ad_oe_q      <= 1'b0;
            par_q        <= 1'b0;
            par_oe_q     <= 1'b0;
            devsel_n_q   <= 1'b1;
            trdy_n_q     <= 1'b1;
            stop_n_q     <= 1'b1;
            ctl_oe_q     <= 1'b0;
            frame_prev_q <= 1'b1;
            irdy_prev_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            ad_q         <= ad_d;
            ad_oe_q      <= ad_oe_d;
            par_q        <= par_d;
            par_oe_q     <= par_oe_d;
            devsel_n_q   <= devsel_n_d;
            trdy_n_q     <= trdy_n_d;
            stop_n_q     <= stop_n_d;
            ctl_oe_q     <= ctl_oe_d;
            frame_prev_q <= bus.pci_frame_ni;
            irdy_prev_q  <= bus.pci_irdy_ni;
        end
    end

    // RAM is deliberately left out of reset so data survives a mid-burst reset.
    always_ff @(posedge pci_clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (!bus.pci_cbe_ni[i]) begin
                    mem[ptr_q][8*i +: 8] <= bus.pci_ad_i[8*i +: 8];
                end
            end
        end
    end

    assign bus.pci_ad_o      = ad_q;
    assign bus.pci_ad_oe_o   = ad_oe_q;
    assign bus.pci_par_o     = par_q;
    assign bus.pci_par_oe_o  = par_oe_q;
    assign bus.pci_devsel_no = devsel_n_q;
    assign bus.pci_trdy_no   = trdy_n_q;
    assign bus.pci_stop_no   = stop_n_q;
    assign bus.pci_ctl_oe_o  = ctl_oe_q;
endmodule
